// File: rtl/miriscv_decode_stage_if.sv
// miriscv_decode_stage_if: fetch-to-decode push handshake carrying {pc, instr}
// Signals: instr_valid (fetch offers), instr_ready (queue not full), instr/pc (payload).
// Modports: master = fetch side, slave = decode stage.
interface miriscv_decode_stage_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  modport master (output instr_valid, instr, pc, input instr_ready);
  modport slave  (input instr_valid, instr, pc, output instr_ready);
endinterface

// File: rtl/miriscv_decode_stage.sv
// miriscv_decode_stage: RV32I(+M) decode stage with an instruction queue and registered control word
// Ports: clk_i, arstn_i (async active-low); flush_i drops queue and output register;
//   fetch (slave) pushes {pc, instr}; level_o is queue occupancy; dec_valid_o/dec_ready_i hand the
//   registered pc, raw word and control fields (ex_*, alu, mem_*, gpr_we, wb, branch/jal/jalr, mdu_*,
//   illegal_instr_o) to execute.
// Optional macro MIRISCV_RV32M_EN: decode OP with funct7=0000001 as an M-extension request.
module miriscv_decode_stage #(
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   arstn_i,
  input  logic                   flush_i,
  miriscv_decode_stage_if.slave  fetch,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   dec_valid_o,
  input  logic                   dec_ready_i,
  output logic [31:0]            dec_pc_o,
  output logic [31:0]            dec_instr_o,
  output logic [1:0]             ex_op_a_sel_o,
  output logic [2:0]             ex_op_b_sel_o,
  output logic [4:0]             alu_op_o,
  output logic                   mem_req_o,
  output logic                   mem_we_o,
  output logic [2:0]             mem_size_o,
  output logic                   gpr_we_a_o,
  output logic                   wb_src_sel_o,
  output logic                   branch_o,
  output logic                   jal_o,
  output logic                   jalr_o,
  output logic                   mdu_req_o,
  output logic [2:0]             mdu_op_o,
  output logic                   illegal_instr_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [4:0] ALU_ADD = 5'b00000;
  typedef struct packed {
    logic [1:0] a_sel;
    logic [2:0] b_sel;
    logic [4:0] alu;
    logic       mem_req;
    logic       mem_we;
    logic [2:0] mem_size;
    logic       gpr_we;
    logic       wb;
    logic       branch;
    logic       jal;
    logic       jalr;
    logic       illegal;
  } ctrl_t;
  logic [63:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic push, load, dec_valid_q, dec_valid_d;
  logic [63:0] head;
  logic [31:0] ins, dec_pc_q, dec_instr_q;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] op;
  logic ill;
  ctrl_t ctrl_d, ctrl_q;
  assign fetch.instr_ready = cnt_q != (AW+1)'(DEPTH);
  assign push = fetch.instr_valid & fetch.instr_ready & ~flush_i;
  assign load = (cnt_q != '0) & (~dec_valid_q | dec_ready_i) & ~flush_i;
  assign wr_ptr_d = flush_i ? '0 : wr_ptr_q + AW'(push);
  assign rd_ptr_d = flush_i ? '0 : rd_ptr_q + AW'(load);
  assign cnt_d = flush_i ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(load);
  assign dec_valid_d = flush_i ? 1'b0 : load ? 1'b1 : dec_ready_i ? 1'b0 : dec_valid_q;
  assign level_o = cnt_q;
  always_ff @(posedge clk_i or negedge arstn_i)
    if (!arstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  // Queue storage is never reset: occupancy alone says which entries are meaningful.
  always_ff @(posedge clk_i)
    if (push) mem_q[wr_ptr_q] <= {fetch.pc, fetch.instr};
  assign head = mem_q[rd_ptr_q];
  assign ins = head[31:0];
  assign f3 = ins[14:12];
  assign f7 = ins[31:25];
  assign op = ins[6:2];
  always_comb begin
    ctrl_d = '0;
    ill = 1'b0;
    case (op)
      5'b00000: begin
        ctrl_d.b_sel = 3'd1;
        ctrl_d.mem_req = 1'b1;
        ctrl_d.wb = 1'b1;
        ctrl_d.gpr_we = 1'b1;
        ctrl_d.mem_size = f3;
        ill = f3 == 3'b011 || f3[2:1] == 2'b11;
      end
      5'b00011: ill = f3 != 3'b000;
      5'b00100: begin
        ctrl_d.b_sel = 3'd1;
        ctrl_d.alu = {1'b0, ins[30] & (f3 == 3'b101), f3};
        ctrl_d.gpr_we = 1'b1;
        ill = (f3 == 3'b001 && f7 != 7'b0) || (f3 == 3'b101 && f7 != 7'b0 && f7 != 7'b0100000);
      end
      5'b00101: begin
        ctrl_d.a_sel = 2'd1;
        ctrl_d.b_sel = 3'd2;
        ctrl_d.gpr_we = 1'b1;
      end
      5'b01000: begin
        ctrl_d.b_sel = 3'd3;
        ctrl_d.mem_req = 1'b1;
        ctrl_d.mem_we = 1'b1;
        ctrl_d.mem_size = f3;
        ill = f3 > 3'b010;
      end
      5'b01100: begin
        ctrl_d.alu = {1'b0, ins[30], f3};
        ctrl_d.gpr_we = 1'b1;
        ill = !(f7 == 7'b0 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
`ifdef MIRISCV_RV32M_EN
        if (f7 == 7'b0000001) begin
          ctrl_d.alu = ALU_ADD;
          ill = 1'b0;
        end
`endif
      end
      5'b01101: begin
        ctrl_d.a_sel = 2'd2;
        ctrl_d.b_sel = 3'd2;
        ctrl_d.gpr_we = 1'b1;
      end
      5'b11000: begin
        ctrl_d.alu = {2'b11, f3};
        ctrl_d.branch = 1'b1;
        ill = f3[2:1] == 2'b01;
      end
      5'b11001: begin
        ctrl_d.a_sel = 2'd1;
        ctrl_d.b_sel = 3'd4;
        ctrl_d.gpr_we = 1'b1;
        ctrl_d.jalr = 1'b1;
        ill = f3 != 3'b000;
      end
      5'b11011: begin
        ctrl_d.a_sel = 2'd1;
        ctrl_d.b_sel = 3'd4;
        ctrl_d.gpr_we = 1'b1;
        ctrl_d.jal = 1'b1;
      end
      default: ill = 1'b1;
    endcase
    if (ins[1:0] != 2'b11) ill = 1'b1;
    // An illegal word must not cause any architectural side effect downstream.
    if (ill) begin
      ctrl_d.mem_req = 1'b0;
      ctrl_d.mem_we = 1'b0;
      ctrl_d.gpr_we = 1'b0;
      ctrl_d.branch = 1'b0;
      ctrl_d.jal = 1'b0;
      ctrl_d.jalr = 1'b0;
    end
    ctrl_d.illegal = ill;
  end
  always_ff @(posedge clk_i or negedge arstn_i)
    if (!arstn_i) begin
      dec_valid_q <= 1'b0;
      dec_pc_q    <= '0;
      dec_instr_q <= '0;
      ctrl_q      <= '0;
    end else begin
      dec_valid_q <= dec_valid_d;
      if (load) begin
        dec_pc_q    <= head[63:32];
        dec_instr_q <= ins;
        ctrl_q      <= ctrl_d;
      end
    end
`ifdef MIRISCV_RV32M_EN
  logic mdu_req_d, mdu_req_q;
  logic [2:0] mdu_op_d, mdu_op_q;
  assign mdu_req_d = ins[6:0] == 7'b0110011 && f7 == 7'b0000001;
  assign mdu_op_d = mdu_req_d ? f3 : 3'b000;
  always_ff @(posedge clk_i or negedge arstn_i)
    if (!arstn_i) begin
      mdu_req_q <= 1'b0;
      mdu_op_q  <= '0;
    end else if (load) begin
      mdu_req_q <= mdu_req_d;
      mdu_op_q  <= mdu_op_d;
    end
  assign mdu_req_o = mdu_req_q;
  assign mdu_op_o = mdu_op_q;
`else
  assign mdu_req_o = 1'b0;
  assign mdu_op_o = 3'b000;
`endif
  assign dec_valid_o = dec_valid_q;
  assign dec_pc_o = dec_pc_q;
  assign dec_instr_o = dec_instr_q;
  assign ex_op_a_sel_o = ctrl_q.a_sel;
  assign ex_op_b_sel_o = ctrl_q.b_sel;
  assign alu_op_o = ctrl_q.alu;
  assign mem_req_o = ctrl_q.mem_req;
  assign mem_we_o = ctrl_q.mem_we;
  assign mem_size_o = ctrl_q.mem_size;
  assign gpr_we_a_o = ctrl_q.gpr_we;
  assign wb_src_sel_o = ctrl_q.wb;
  assign branch_o = ctrl_q.branch;
  assign jal_o = ctrl_q.jal;
  assign jalr_o = ctrl_q.jalr;
  assign illegal_instr_o = ctrl_q.illegal;
endmodule
